mem_axi_burst: RTL
==================

# mem_axi_burst

AXI4 master bridge that turns one request from a core-side memory port into a single-ID INCR burst of 1..MAX_BURST beats on an AXI4 interconnect. It generalises the word-at-a-time memory-to-AXI bridge: configurable data width, read/write bursts with streamed data, request/done handshakes, response-error reporting and 4 KB-boundary protection. It sits between the switch's table/packet-buffer engines and the shared AXI memory fabric, one instance per requester.

## Interface
- AXI_ID, 0: value driven on axi_awid/axi_arid
- ID_WIDTH, 4: AXI ID width
- DATA_WIDTH, 32: data bus width, 32 or 64
- MAX_BURST, 16: largest burst in beats, 1..256
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid / req_ready  in / out  1  request handshake
- req_we  in  1  1 = write burst, 0 = read burst
- req_addr  in  32  byte address; low log2(DATA_WIDTH/8) bits ignored (forced 0)
- req_len  in  8  beats minus 1
- wr_data / wr_valid / wr_ready  in / in / out  DATA_WIDTH / 1 / 1  write-beat stream
- rd_data / rd_valid / rd_last / rd_ready  out / out / out / in  DATA_WIDTH / 1 / 1 / 1  read-beat stream
- done_o / err_o  out  1  one-cycle completion pulse; err_o qualified by done_o
- axi_aw*: awid[ID_WIDTH], awaddr[32], awlen[8], awsize[3], awburst[2], awvalid out; awready in
- axi_w*: wdata[DATA_WIDTH], wstrb[DATA_WIDTH/8] (all ones), wlast, wvalid out; wready in
- axi_b*: bid, bresp[2], bvalid in; bready out
- axi_ar*: arid, araddr[32], arlen[8], arsize[3], arburst[2], arvalid out; arready in
- axi_r*: rid, rdata, rresp[2], rlast, rvalid in; rready out

## Operation
- States: IDLE, CHK, AR, R, AWW, B, DONE.
- IDLE: req_ready=1. On req_valid&req_ready latch we, aligned addr, len → CHK.
- CHK: err if req_len > MAX_BURST-1, or addr[11:0] + (len+1)*DATA_WIDTH/8 > 4096 → DONE with err=1, no AXI traffic. Else → AR (read) or AWW (write).
- AR: arvalid=1, araddr, arlen=len, arsize=log2(DATA_WIDTH/8), arburst=INCR(01); on arready → R.
- R: rd_data=axi_rdata, rd_valid=axi_rvalid, axi_rready=rd_ready (combinational pass-through). rd_last high when beat count == len. Each accepted beat increments count. rresp≠OKAY sets sticky err. axi_rlast asserted at count≠len, or absent at count==len, sets err. On final accepted beat → DONE.
- AWW: awvalid high until awready (aw_done flag); W pass-through: axi_wdata=wr_data, axi_wvalid=wr_valid, wr_ready=axi_wready; wlast when count==len. When aw_done and last W beat both complete (any order, same cycle allowed) → B.
- B: bready=1; on bvalid, bresp≠OKAY sets err → DONE.
- DONE: done_o=1, err_o=sticky err, one cycle → IDLE; err and count cleared.
- bready held 1 and rready driven only in B / R respectively; all other cycles rready=0, wr_ready=0, rd_valid=0.
- bid/rid not checked.

## Timing
- Reset (rst=0, async): state IDLE; arvalid, awvalid, wvalid, done_o, err_o, rd_valid, wr_ready, rready, bready = 0; araddr/awaddr/awlen/arlen = 0; req_ready = 1 after release. Reset mid-burst abandons the AXI transaction immediately (valids drop asynchronously).
- awvalid/arvalid registered: first high one cycle after CHK; held stable until ready (AXI rule).
- Min read latency: accept (T0) → CHK (T1) → arvalid (T2); done_o at cycle after last R beat.
- Error-reject latency: req accepted T0, done_o=err_o=1 at T2.
- One outstanding transaction; back-to-back request accepted the cycle after done_o.
- Downstream stalls (rd_ready=0) stall the AXI R channel; upstream wr_valid=0 inserts W bubbles.

## Test plan
- Read len=3, addr 0x100, DATA_WIDTH=32, slave returns 0xA0..0xA3 OKAY → araddr=0x100, arlen=3, arsize=2, 4 rd beats, rd_last on 4th, done_o, err_o=0.
- Write len=0, addr 0x203 → awaddr=0x200, wlast on single beat, wstrb=0xF; slave gives W before AW → still completes; bresp=SLVERR(10) → err_o=1.
- addr 0xFF8, len=3, DATA_WIDTH=32 → no arvalid/awvalid, done_o=err_o=1 two cycles after accept.
- Read len=7 with rd_ready toggling and slave rlast early at beat 5 → rready follows rd_ready, err_o=1 at done.
- req_len=16 with MAX_BURST=16 → rejected, err_o=1; len=15 accepted.
- rst low during write beat 2 of 4 → all valids 0 same cycle; after release, req_ready=1 and new read completes normally.

Source files
------------

// File: rtl/mem_axi_burst.sv
// Core-side memory port to AXI4 burst master bridge.
// One request becomes one single-ID INCR burst of 1..MAX_BURST beats; read and write
// data stream straight through, and a one-cycle done_o/err_o pulse reports completion.
module mem_axi_burst #(
   parameter int unsigned AXI_ID     = 0,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_BURST  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   // core-side request
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [31:0]               req_addr,
   input  logic [7:0]                req_len,
   // core-side write stream
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   // core-side read stream
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      rd_valid,
   output logic                      rd_last,
   input  logic                      rd_ready,
   // completion
   output logic                      done_o,
   output logic                      err_o,
   // AXI write address
   output logic [ID_WIDTH-1:0]       axi_awid,
   output logic [31:0]               axi_awaddr,
   output logic [7:0]                axi_awlen,
   output logic [2:0]                axi_awsize,
   output logic [1:0]                axi_awburst,
   output logic                      axi_awvalid,
   input  logic                      axi_awready,
   // AXI write data
   output logic [DATA_WIDTH-1:0]     axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
   output logic                      axi_wlast,
   output logic                      axi_wvalid,
   input  logic                      axi_wready,
   // AXI write response
   input  logic [ID_WIDTH-1:0]       axi_bid,
   input  logic [1:0]                axi_bresp,
   input  logic                      axi_bvalid,
   output logic                      axi_bready,
   // AXI read address
   output logic [ID_WIDTH-1:0]       axi_arid,
   output logic [31:0]               axi_araddr,
   output logic [7:0]                axi_arlen,
   output logic [2:0]                axi_arsize,
   output logic [1:0]                axi_arburst,
   output logic                      axi_arvalid,
   input  logic                      axi_arready,
   // AXI read data
   input  logic [ID_WIDTH-1:0]       axi_rid,
   input  logic [DATA_WIDTH-1:0]     axi_rdata,
   input  logic [1:0]                axi_rresp,
   input  logic                      axi_rlast,
   input  logic                      axi_rvalid,
   output logic                      axi_rready
);

   localparam int unsigned        BYTES     = DATA_WIDTH / 8;
   localparam int unsigned        SIZE_LOG2 = $clog2(BYTES);
   localparam logic [2:0]         AXSIZE    = 3'(SIZE_LOG2);
   localparam logic [ID_WIDTH-1:0] ID_VAL   = ID_WIDTH'(AXI_ID);
   localparam logic [31:0]        ADDR_MASK = ~(32'(BYTES - 1));
   localparam logic [8:0]         MAX_LEN   = 9'(MAX_BURST - 1);
   localparam logic [1:0]         RESP_OKAY = 2'b00;
   localparam logic [1:0]         BURST_INC = 2'b01;

   typedef enum logic [2:0] {StIdle, StChk, StAr, StR, StAww, StB, StDone} state_e;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  count_q, count_d;
   logic        err_q, err_d;
   logic        arvalid_q, arvalid_d;
   logic        awvalid_q, awvalid_d;
   logic        w_done_q, w_done_d;

   logic [13:0] burst_bytes;
   logic [13:0] end_offs;
   logic        chk_err;
   logic        beat_last;
   logic        r_hs;
   logic        w_hs;
   logic        aw_ok;
   logic        w_ok;
   logic        unused_ids;

   // IDs are not checked; single outstanding transaction
   assign unused_ids = ^{axi_bid, axi_rid};

   // Burst must fit under MAX_BURST and must not cross a 4 KB page
   assign burst_bytes = (14'(len_q) + 14'd1) << SIZE_LOG2;
   assign end_offs    = 14'(addr_q[11:0]) + burst_bytes;
   assign chk_err     = ({1'b0, len_q} > MAX_LEN) || (end_offs > 14'd4096);

   assign beat_last = (count_q == len_q);
   assign r_hs      = (state_q == StR) && axi_rvalid && rd_ready;
   assign w_hs      = (state_q == StAww) && !w_done_q && wr_valid && axi_wready;
   // AW and the final W beat may complete in either order or together
   assign aw_ok     = !awvalid_q || axi_awready;
   assign w_ok      = w_done_q || (w_hs && beat_last);

   // State and datapath registers; async reset drops all valids at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         we_q      <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         count_q   <= count_d;
         err_q     <= err_d;
         arvalid_q <= arvalid_d;
         awvalid_q <= awvalid_d;
         w_done_q  <= w_done_d;
      end
   end

   // Next-state logic: request capture, checks, beat counting and sticky error
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      addr_d    = addr_q;
      len_d     = len_q;
      count_d   = count_q;
      err_d     = err_q;
      arvalid_d = arvalid_q;
      awvalid_d = awvalid_q;
      w_done_d  = w_done_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr & ADDR_MASK;
               len_d   = req_len;
               state_d = StChk;
            end
         end
         StChk: begin
            if (chk_err) begin
               err_d   = 1'b1;
               state_d = StDone;
            end else if (we_q) begin
               awvalid_d = 1'b1;
               state_d   = StAww;
            end else begin
               arvalid_d = 1'b1;
               state_d   = StAr;
            end
         end
         StAr: begin
            if (axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = StR;
            end
         end
         StR: begin
            if (r_hs) begin
               if (axi_rresp != RESP_OKAY) err_d = 1'b1;
               if (axi_rlast != beat_last) err_d = 1'b1;
               if (beat_last) state_d = StDone;
               else           count_d = count_q + 8'd1;
            end
         end
         StAww: begin
            if (axi_awready) awvalid_d = 1'b0;
            if (w_hs) begin
               if (beat_last) w_done_d = 1'b1;
               else           count_d  = count_q + 8'd1;
            end
            if (aw_ok && w_ok) state_d = StB;
         end
         StB: begin
            if (axi_bvalid) begin
               if (axi_bresp != RESP_OKAY) err_d = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            err_d    = 1'b0;
            count_d  = '0;
            w_done_d = 1'b0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs: registered address channels, state-gated stream pass-through
   always_comb begin
      req_ready   = (state_q == StIdle);
      done_o      = (state_q == StDone);
      err_o       = (state_q == StDone) && err_q;

      axi_arid    = ID_VAL;
      axi_araddr  = addr_q;
      axi_arlen   = len_q;
      axi_arsize  = AXSIZE;
      axi_arburst = BURST_INC;
      axi_arvalid = arvalid_q;

      rd_data     = axi_rdata;
      rd_valid    = (state_q == StR) && axi_rvalid;
      rd_last     = (state_q == StR) && beat_last;
      axi_rready  = (state_q == StR) && rd_ready;

      axi_awid    = ID_VAL;
      axi_awaddr  = addr_q;
      axi_awlen   = len_q;
      axi_awsize  = AXSIZE;
      axi_awburst = BURST_INC;
      axi_awvalid = awvalid_q;

      axi_wdata   = wr_data;
      axi_wstrb   = '1;
      axi_wlast   = (state_q == StAww) && beat_last;
      axi_wvalid  = (state_q == StAww) && !w_done_q && wr_valid;
      wr_ready    = (state_q == StAww) && !w_done_q && axi_wready;

      axi_bready  = (state_q == StB);
   end

endmodule
